cpu_bus_responder: RTL

- Target side of the CPU external bus: answers each address the core presents with read data, accepts writes, and stalls the core while slow targets respond.
- Serves three regions:
  - 2 KiB internal work RAM, mirrored.
  - Fixed interrupt/reset vector bytes.
  - Everything else, forwarded to an external slave over a req/ack handshake.
- Sits between the CPU core and the cartridge/PPU/APU fabric. The CPU top instantiates it beside the core.

---
 rtl/cpu_bus_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_responder.sv
// CPU external-bus target: answers reads and writes to the mirrored work RAM and the
// vector bytes. All other addresses go to an external slave over a req/ack handshake.
// The core is stalled through rdy while an external access is outstanding.
module cpu_bus_responder #(
    parameter int unsigned RAM_AW  = 11,
    parameter logic [15:0] RAM_END = 16'h1FFF,
    parameter logic [15:0] NMI_VEC = 16'h8000,
    parameter logic [15:0] RST_VEC = 16'h8000,
    parameter logic [15:0] IRQ_VEC = 16'h8000,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        rw,
    input  logic [7:0]  d_in,
    input  logic        sync,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        rdy,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    output logic [15:0] fetch_addr,
    output logic        timeout_err
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit for TIMEOUT = 1.
    localparam int unsigned   CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [7:0]        d_out_q, d_out_d;
    logic              d_oe_q, d_oe_d;
    logic              ext_req_q, ext_req_d;
    logic              ext_we_q, ext_we_d;
    logic [15:0]       ext_addr_q, ext_addr_d;
    logic [7:0]        ext_wdata_q, ext_wdata_d;
    logic [15:0]       fetch_addr_q, fetch_addr_d;
    logic              timeout_err_q, timeout_err_d;
    logic [7:0]        open_bus_q, open_bus_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;

    logic [7:0]        ram_q [(1 << RAM_AW)];
    logic [RAM_AW-1:0] ram_idx;
    logic [7:0]        ram_rdata;
    logic              ram_we;
    logic [15:0]       vec_word;
    logic [7:0]        vec_byte;

    assign ram_idx   = a[RAM_AW-1:0];
    assign ram_rdata = ram_q[ram_idx];

    // Vector byte lookup: word chosen by address pair, byte by a[0].
    always_comb begin
        vec_word = IRQ_VEC;
        if (a < 16'hFFFC) begin
            vec_word = NMI_VEC;
        end else if (a < 16'hFFFE) begin
            vec_word = RST_VEC;
        end
        vec_byte = a[0] ? vec_word[15:8] : vec_word[7:0];
    end

    // Work RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= d_in;
        end
    end

    // Next-state and output decode for the IDLE/WAIT/RESP access sequencer.
    always_comb begin
        state_d       = state_q;
        d_out_d       = d_out_q;
        d_oe_d        = 1'b0;
        ext_req_d     = ext_req_q;
        ext_we_d      = ext_we_q;
        ext_addr_d    = ext_addr_q;
        ext_wdata_d   = ext_wdata_q;
        fetch_addr_d  = fetch_addr_q;
        timeout_err_d = timeout_err_q;
        open_bus_d    = open_bus_q;
        wait_cnt_d    = wait_cnt_q;
        ram_we        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rw && sync) begin
                    fetch_addr_d = a;
                end
                if (a <= RAM_END) begin
                    if (rw) begin
                        d_out_d    = ram_rdata;
                        d_oe_d     = 1'b1;
                        open_bus_d = ram_rdata;
                    end else begin
                        ram_we = ~rst;
                    end
                end else if (a >= 16'hFFFA) begin
                    // Writes to the vector bytes are dropped.
                    if (rw) begin
                        d_out_d    = vec_byte;
                        d_oe_d     = 1'b1;
                        open_bus_d = vec_byte;
                    end
                end else begin
                    ext_req_d   = 1'b1;
                    ext_addr_d  = a;
                    ext_we_d    = ~rw;
                    ext_wdata_d = d_in;
                    wait_cnt_d  = '0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (ext_ack) begin
                    ext_req_d = 1'b0;
                    ext_we_d  = 1'b0;
                    state_d   = StResp;
                    if (!ext_we_q) begin
                        d_out_d    = ext_rdata;
                        d_oe_d     = 1'b1;
                        open_bus_d = ext_rdata;
                    end
                end else if (wait_cnt_q == CntMax) begin
                    ext_req_d     = 1'b0;
                    ext_we_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = StResp;
                    if (!ext_we_q) begin
                        d_out_d = open_bus_q;
                        d_oe_d  = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StResp: begin
                // Leaving RESP never samples a new access.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            d_out_q       <= 8'h00;
            d_oe_q        <= 1'b0;
            ext_req_q     <= 1'b0;
            ext_we_q      <= 1'b0;
            ext_addr_q    <= 16'h0000;
            ext_wdata_q   <= 8'h00;
            fetch_addr_q  <= 16'h0000;
            timeout_err_q <= 1'b0;
            open_bus_q    <= 8'h00;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            d_out_q       <= d_out_d;
            d_oe_q        <= d_oe_d;
            ext_req_q     <= ext_req_d;
            ext_we_q      <= ext_we_d;
            ext_addr_q    <= ext_addr_d;
            ext_wdata_q   <= ext_wdata_d;
            fetch_addr_q  <= fetch_addr_d;
            timeout_err_q <= timeout_err_d;
            open_bus_q    <= open_bus_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign d_out       = d_out_q;
    assign d_oe        = d_oe_q;
    assign rdy         = (state_q != StWait);
    assign ext_req     = ext_req_q;
    assign ext_we      = ext_we_q;
    assign ext_addr    = ext_addr_q;
    assign ext_wdata   = ext_wdata_q;
    assign fetch_addr  = fetch_addr_q;
    assign timeout_err = timeout_err_q;

endmodule
